// File: rtl/class_demux_fifo.sv
// Class demultiplexer: routes each non-zero input word into one of four per-class FIFOs by its top
// two bits and provides four pop ports with registered read data. Optional CLASS_DEMUX_DROP_CNT_EN.
module class_demux_fifo #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AFULL_THR  = 3
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [3:0]            pop,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [DATA_WIDTH-1:0] data_out3,
  output logic [3:0]            valid_out,
  output logic [3:0]            empty,
  output logic [3:0]            full,
  output logic [3:0]            almost_full,
  output logic [3:0]            err_overflow
`ifdef CLASS_DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic                       w_push_vld;
  logic [1:0]                 w_cls;
  logic [3:0]                 w_drop;
  logic [3:0][DATA_WIDTH-1:0] w_dout;

  assign w_push_vld = |data_in;
  assign w_cls      = data_in[DATA_WIDTH-1 -: 2];

  for (genvar g = 0; g < 4; g++) begin : g_fifo
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic                  r_err;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push_req;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CW'(DEPTH));
    assign w_push_req = w_push_vld && (w_cls == 2'(g));
    assign w_pop_ok   = pop[g] && !w_empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted.
    assign w_push_ok  = w_push_req && (!w_full || w_pop_ok);
    assign w_drop[g]  = w_push_req && w_full && !w_pop_ok;

    // Storage is not reset; only pointers and counts define validity.
    always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_cnt   <= '0;
        r_dout  <= '0;
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + 1'b1;
        if (w_pop_ok) begin
          r_rptr <= r_rptr + 1'b1;
          r_dout <= r_mem[r_rptr];
        end
        if (w_push_ok && !w_pop_ok)      r_cnt <= r_cnt + 1'b1;
        else if (w_pop_ok && !w_push_ok) r_cnt <= r_cnt - 1'b1;
        r_valid <= w_pop_ok;
        if (w_drop[g]) r_err <= 1'b1;
      end
    end

    assign empty[g]        = w_empty;
    assign full[g]         = w_full;
    assign almost_full[g]  = (r_cnt >= CW'(AFULL_THR));
    assign valid_out[g]    = r_valid;
    assign err_overflow[g] = r_err;
    assign w_dout[g]       = r_dout;
  end

  assign data_out0 = w_dout[0];
  assign data_out1 = w_dout[1];
  assign data_out2 = w_dout[2];
  assign data_out3 = w_dout[3];

`ifdef CLASS_DEMUX_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // At most one word arrives per cycle, so at most one drop per cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_drop_cnt <= '0;
    end else if (|w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_class_demux_fifo.sv
// Bench for class_demux_fifo: directed scenarios then random traffic, all checked against a
// queue-based model of four bounded per-class FIFOs.
module tb_class_demux_fifo;

  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFT   = 3;

  logic          clk;
  logic          reset_L;
  logic [DW-1:0] data_in;
  logic [3:0]    pop;
  logic [DW-1:0] dout0, dout1, dout2, dout3;
  logic [3:0]    valid_out, empty, full, almost_full, err_overflow;
  logic [3:0][DW-1:0] dout_p;
`ifdef CLASS_DEMUX_DROP_CNT_EN
  logic [7:0]    drop_count;
`endif

  assign dout_p = {dout3, dout2, dout1, dout0};

  class_demux_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AFULL_THR (AFT)
  ) u_dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .pop         (pop),
    .data_out0   (dout0),
    .data_out1   (dout1),
    .data_out2   (dout2),
    .data_out3   (dout3),
    .valid_out   (valid_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .err_overflow(err_overflow)
`ifdef CLASS_DEMUX_DROP_CNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [DW-1:0] mq [4][$];
  logic [DW-1:0] m_dout [4];
  logic [3:0]    m_valid;
  logic [3:0]    m_err;
  int            m_drops;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      m_dout[i] = '0;
    end
    m_valid = '0;
    m_err   = '0;
    m_drops = 0;
  endtask

  task automatic check_flags(input string tag);
    logic [3:0] e, f, af;
    for (int i = 0; i < 4; i++) begin
      e[i]  = (mq[i].size() == 0);
      f[i]  = (mq[i].size() == DEPTH);
      af[i] = (mq[i].size() >= AFT);
    end
    check_eq({tag, "_empty"}, 32'(empty), 32'(e));
    check_eq({tag, "_full"}, 32'(full), 32'(f));
    check_eq({tag, "_afull"}, 32'(almost_full), 32'(af));
  endtask

  task automatic check_outs(input string tag);
    check_eq({tag, "_valid"}, 32'(valid_out), 32'(m_valid));
    check_eq({tag, "_err"}, 32'(err_overflow), 32'(m_err));
    for (int i = 0; i < 4; i++) check_eq($sformatf("%s_dout%0d", tag, i), 32'(dout_p[i]), 32'(m_dout[i]));
`ifdef CLASS_DEMUX_DROP_CNT_EN
    check_eq({tag, "_dropcnt"}, 32'(drop_count), 32'(m_drops));
`endif
  endtask

  // One clock cycle: called at posedge+1; checks pre-edge flags, advances model and DUT.
  task automatic drive(input logic [DW-1:0] din, input logic [3:0] p, input string tag);
    logic [3:0] pok;
    int         c;
    bit         do_push;
    data_in = din;
    pop     = p;
    #1;
    check_flags(tag);
    for (int i = 0; i < 4; i++) pok[i] = p[i] && (mq[i].size() > 0);
    do_push = 1'b0;
    c       = int'(din[DW-1 -: 2]);
    if (din != '0) begin
      if (mq[c].size() < DEPTH || pok[c]) begin
        do_push = 1'b1;
      end else begin
        m_err[c] = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    for (int i = 0; i < 4; i++) if (pok[i]) m_dout[i] = mq[i].pop_front();
    m_valid = pok;
    if (do_push) mq[c].push_back(din);
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic async_reset(input string tag);
    data_in = '0;
    pop     = '0;
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_eq({tag, "_rst_empty"}, 32'(empty), 32'hF);
    check_eq({tag, "_rst_err"}, 32'(err_overflow), 32'h0);
    check_eq({tag, "_rst_d0"}, 32'(dout0), 32'h0);
    check_eq({tag, "_rst_valid"}, 32'(valid_out), 32'h0);
    #3;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] din;
    logic [3:0]    p;
    reset_L = 1'b0;
    data_in = '0;
    pop     = '0;
    model_reset();
    #12;
    check_flags("reset");
    check_outs("reset");
    reset_L = 1'b1;
    @(posedge clk);
    #1;

    // Idle with pops on empty FIFOs
    for (int k = 0; k < 10; k++) drive('0, 4'b1111, "idle");

    // One word per class, then pop all four
    drive(12'h005, 4'b0000, "tp1");
    drive(12'h403, 4'b0000, "tp1");
    drive(12'h8AA, 4'b0000, "tp1");
    drive(12'hC01, 4'b0000, "tp1");
    drive('0, 4'b1111, "tp1_pop");
    check_eq("tp1_d0_const", 32'(dout0), 32'h005);
    check_eq("tp1_d3_const", 32'(dout3), 32'hC01);

    // Fill class 1, overflow, drain
    drive(12'h401, 4'b0000, "tp2");
    drive(12'h402, 4'b0000, "tp2");
    drive(12'h403, 4'b0000, "tp2");
    drive(12'h404, 4'b0000, "tp2");
    drive(12'h405, 4'b0000, "tp2_drop");
    check_eq("tp2_err1_const", 32'(err_overflow[1]), 32'h1);
`ifdef CLASS_DEMUX_DROP_CNT_EN
    check_eq("tp2_dropcnt_const", 32'(drop_count), 32'h1);
`endif
    for (int k = 0; k < 4; k++) drive('0, 4'b0010, "tp2_pop");
    check_eq("tp2_last_const", 32'(dout1), 32'h404);

    // Class 2: wrap pointers, fill, then push+pop while full
    for (int k = 0; k < 8; k++) drive(12'h810 + DW'(k), 4'b0100, "tp3_wrap");
    drive('0, 4'b0100, "tp3_wrap");
    for (int k = 0; k < 4; k++) drive(12'h8A1 + DW'(k), 4'b0000, "tp3_fill");
    drive(12'h8FF, 4'b0100, "tp3_pp");
    check_eq("tp3_d2_const", 32'(dout2), 32'h8A1);
    check_eq("tp3_full_const", 32'(full[2]), 32'h1);
    for (int k = 0; k < 4; k++) drive('0, 4'b0100, "tp3_drain");
    check_eq("tp3_last_const", 32'(dout2), 32'h8FF);

    // Class 3 empty: push+pop same cycle, no bypass
    drive(12'hC07, 4'b1000, "tp4_pp");
    check_eq("tp4_valid3_const", 32'(valid_out[3]), 32'h0);
    drive('0, 4'b1000, "tp4_pop");
    check_eq("tp4_d3_const", 32'(dout3), 32'hC07);

    // Asynchronous reset with state present
    drive(12'h011, 4'b0000, "tp6");
    drive(12'h012, 4'b0000, "tp6");
    async_reset("tp6");

    // Random traffic, alternating fill-biased and drain-biased phases
    for (int k = 0; k < 800; k++) begin
      if (k == 400) async_reset("rnd");
      if ($urandom_range(0, 3) == 0) din = '0;
      else din = {2'($urandom_range(0, 3)), 10'($urandom_range(1, 1023))};
      for (int i = 0; i < 4; i++)
        p[i] = ((k / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(din, p, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
